// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with built-in baud divider, optional parity/2 stop bits.
// Define UART_TX_BREAK_EN to add the tx_break input (line break + mark-after-break).
module uart_tx_param #(
    parameter int CLK_FREQ  = 12_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef UART_TX_BREAK_EN
    input  logic                 tx_break,
`endif
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 frame_done,
    output logic                 uart_tx
);

    localparam int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW       = $clog2(BAUD_DIV);
    localparam int MAXB     = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BW       = $clog2(MAXB);

    if (BAUD_DIV < 2) begin : g_div_chk
        $error("uart_tx_param: BAUD_DIV must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_par_chk
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP, BRK, MARK} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        baud_cnt, baud_nx;
    logic [BW-1:0]        bit_cnt, bit_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 par_bit, par_nx;
    logic                 ready_r, ready_nx;
    logic                 line_nx, busy_nx, done_nx;
    logic                 boundary;

`ifdef UART_TX_BREAK_EN
    assign tx_ready = ready_r & ~tx_break;
`else
    assign tx_ready = ready_r;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            ready_r    <= 1'b1;
            uart_tx    <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            baud_cnt   <= baud_nx;
            bit_cnt    <= bit_nx;
            shreg      <= shreg_nx;
            par_bit    <= par_nx;
            ready_r    <= ready_nx;
            uart_tx    <= line_nx;
            tx_busy    <= busy_nx;
            frame_done <= done_nx;
        end
    end

    always_comb begin
        boundary = (baud_cnt == CW'(BAUD_DIV - 1));
        state_nx = state;
        baud_nx  = boundary ? '0 : baud_cnt + 1'b1;
        bit_nx   = bit_cnt;
        shreg_nx = shreg;
        par_nx   = par_bit;
        ready_nx = ready_r;
        line_nx  = uart_tx;
        busy_nx  = tx_busy;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                baud_nx = '0;
                bit_nx  = '0;
`ifdef UART_TX_BREAK_EN
                if (tx_break) begin
                    state_nx = BRK;
                    line_nx  = 1'b0;
                    ready_nx = 1'b0;
                end else
`endif
                if (tx_valid && tx_ready) begin
                    state_nx = START;
                    line_nx  = 1'b0;
                    ready_nx = 1'b0;
                    busy_nx  = 1'b1;
                    shreg_nx = tx_data;
                    par_nx   = (PARITY == 1) ? ~^tx_data : ^tx_data;
                end
            end
            START: if (boundary) begin
                state_nx = DATA;
                line_nx  = shreg[0];
            end
            DATA: if (boundary) begin
                if (bit_cnt == BW'(DATA_BITS - 1)) begin
                    bit_nx = '0;
                    if (PARITY != 0) begin
                        state_nx = PAR_BIT;
                        line_nx  = par_bit;
                    end else begin
                        state_nx = STOP;
                        line_nx  = 1'b1;
                    end
                end else begin
                    // next bit is pre-read from shreg[1] so the line updates on this edge
                    bit_nx   = bit_cnt + 1'b1;
                    shreg_nx = shreg >> 1;
                    line_nx  = shreg[1];
                end
            end
            PAR_BIT: if (boundary) begin
                state_nx = STOP;
                line_nx  = 1'b1;
            end
            STOP: if (boundary) begin
                if (bit_cnt == BW'(STOP_BITS - 1)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    ready_nx = 1'b1;
                    busy_nx  = 1'b0;
                end else begin
                    bit_nx = bit_cnt + 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            BRK: begin
                baud_nx = '0;
                if (!tx_break) begin
                    state_nx = MARK;
                    line_nx  = 1'b1;
                end
            end
            // mark-after-break: two full bit periods of idle-high before accepting again
            MARK: if (boundary) begin
                if (bit_cnt == BW'(1)) begin
                    state_nx = IDLE;
                    ready_nx = 1'b1;
                end else begin
                    bit_nx = bit_cnt + 1'b1;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations (8N1, 7E2, 7O2) at BAUD_DIV=10,
// expected frames queued at drive time and compared cycle-by-cycle on the line.
module tb_uart_tx_param;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] valid, ready, busy, done, line;
    logic [7:0] data0;
    logic [6:0] data1, data2;
    logic       brk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_d0 (
        .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk),
`endif
        .tx_valid(valid[0]), .tx_ready(ready[0]), .tx_data(data0),
        .tx_busy(busy[0]), .frame_done(done[0]), .uart_tx(line[0]));

    uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_d1 (
        .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk),
`endif
        .tx_valid(valid[1]), .tx_ready(ready[1]), .tx_data(data1),
        .tx_busy(busy[1]), .frame_done(done[1]), .uart_tx(line[1]));

    uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_d2 (
        .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk),
`endif
        .tx_valid(valid[2]), .tx_ready(ready[2]), .tx_data(data2),
        .tx_busy(busy[2]), .frame_done(done[2]), .uart_tx(line[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line sequence (LSB = first bit on the wire) for instance k.
    function automatic exp_t mk(input int k, input logic [8:0] d);
        exp_t e;
        int db, pr, sp, ones;
        db = (k == 0) ? 8 : 7;
        pr = (k == 0) ? 0 : ((k == 1) ? 2 : 1);
        sp = (k == 0) ? 1 : 2;
        e.bits = '0;
        ones = 0;
        for (int i = 0; i < db; i++) begin
            e.bits[1 + i] = d[i];
            ones += int'(d[i]);
        end
        e.n = 1 + db;
        if (pr != 0) begin
            e.bits[e.n] = (pr == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            e.n++;
        end
        for (int s = 0; s < sp; s++) begin
            e.bits[e.n] = 1'b1;
            e.n++;
        end
        return e;
    endfunction

    task automatic send(input int k, input logic [8:0] d);
        int t;
        sb.push_back(mk(k, d));
        t = 0;
        @(negedge clk);
        while (ready[k] !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (ready[k] !== 1'b1) chk("ready_timeout", 32'(t), 0);
        case (k)
            0: data0 = d[7:0];
            1: data1 = d[6:0];
            default: data2 = d[6:0];
        endcase
        valid[k] = 1'b1;
        @(posedge clk);
        #1 valid[k] = 1'b0;
    endtask

    // Waits for the start bit, then checks every cycle of the frame against the oldest expectation.
    task automatic capture(input int k, output int waited);
        exp_t        e;
        logic [15:0] obs;
        int          bad;
        waited = 0;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        @(negedge clk);
        while (line[k] !== 1'b0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (line[k] !== 1'b0) begin
            chk("start_timeout", 32'(waited), 0);
            return;
        end
        obs = '0;
        bad = 0;
        for (int j = 0; j < e.n * DIV; j++) begin
            if (j > 0) @(negedge clk);
            if (line[k] !== e.bits[j / DIV] || done[k] !== 1'b0 || busy[k] !== 1'b1 || ready[k] !== 1'b0)
                bad++;
            if (j % DIV == DIV / 2) obs[j / DIV] = line[k];
        end
        chk("frame_bits", 32'(obs), 32'(e.bits));
        chk("frame_timing", 32'(bad), 0);
        @(negedge clk);
        chk("frame_done", 32'(done[k]), 1);
        chk("ready_at_done", 32'(ready[k]), 1);
        chk("busy_at_done", 32'(busy[k]), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w, w1, w2, bad, hi, t;
        rst   = 1'b1;
        valid = '0;
        data0 = '0;
        data1 = '0;
        data2 = '0;
        brk   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_line", 32'(line), 32'h7);
        chk("rst_ready", 32'(ready), 32'h7);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;

        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (line !== 3'b111 || ready !== 3'b111 || busy !== 3'b000 || done !== 3'b000) bad++;
        end
        chk("idle_50", 32'(bad), 0);

        send(0, 9'h0A5);
        capture(0, w);
        chk("start_latency", 32'(w), 0);
        send(0, 9'h000); capture(0, w);
        send(0, 9'h0FF); capture(0, w);
        repeat (2) begin
            send(0, 9'($urandom_range(0, 255)));
            capture(0, w);
        end

        send(1, 9'h041); capture(1, w);
        send(1, 9'($urandom_range(0, 127))); capture(1, w);
        send(2, 9'h041); capture(2, w);
        send(2, 9'h07F); capture(2, w);

        // back-to-back with tx_valid held; data changes mid-frame
        sb.push_back(mk(0, 9'h055));
        sb.push_back(mk(0, 9'h0FF));
        @(negedge clk);
        data0    = 8'h55;
        valid[0] = 1'b1;
        fork
            begin
                repeat (30) @(negedge clk);
                data0 = 8'hFF;
            end
            begin
                int tt;
                tt = 0;
                @(posedge clk);
                #1;
                while (done[0] !== 1'b1 && tt < 400) begin
                    @(negedge clk);
                    tt++;
                end
                @(posedge clk);
                #1 valid[0] = 1'b0;
            end
            begin
                capture(0, w1);
                capture(0, w2);
            end
        join
        chk("b2b_first_lat", 32'(w1), 0);
        chk("b2b_gap", 32'(w2), 0);

        // reset mid-frame
        @(negedge clk);
        data0    = 8'h00;
        valid[0] = 1'b1;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        repeat (35) @(negedge clk);
        chk("pre_rst_line", 32'(line[0]), 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_line", 32'(line[0]), 1);
        chk("rst_mid_busy", 32'(busy[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (done[0] !== 1'b0 || line[0] !== 1'b1) bad++;
        end
        chk("rst_no_frame", 32'(bad), 0);
        chk("rst_ready", 32'(ready[0]), 1);

`ifdef UART_TX_BREAK_EN
        @(negedge clk);
        brk = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (line !== 3'b000 || ready !== 3'b000) bad++;
        end
        chk("brk_low", 32'(bad), 0);
        brk = 1'b0;
        hi  = 0;
        bad = 0;
        t   = 0;
        @(negedge clk);
        while (ready[0] !== 1'b1 && t < 200) begin
            if (line[0] === 1'b1) hi++;
            else if (hi > 0) bad++;
            @(negedge clk);
            t++;
        end
        chk("mab_min", 32'(hi >= 2 * DIV), 1);
        chk("mab_glitch", 32'(bad), 0);
        chk("mab_ready", 32'(ready[0]), 1);
        send(0, 9'h03C);
        capture(0, w);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter; successor to the fixed 8N1 transmitter.
- Integrates its own baud-rate divider, so no external bps_en/bps_clk pairing.
- Configurable data width, parity and stop bits; ready/valid input handshake.
- Sits between any byte/word producer (FIFO, command engine) and the board TX pin.

Parameters:
- CLK_FREQ, 12_000_000: system clock frequency in Hz.
- BAUD, 115_200: line rate in bit/s.
  - BAUD_DIV = (CLK_FREQ + BAUD/2) / BAUD, computed as a localparam.
  - BAUD_DIV must be >= 2; elaboration-time check.
- DATA_BITS, 8: payload bits per frame, legal 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal values 1 or 2.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word this cycle.
- tx_data  input  DATA_BITS  word to transmit; LSB sent first.
- tx_busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse at end of last stop bit.
- uart_tx  output  1  serial line, idle high.

Behaviour:
- Reset (async assert; deassert sampled on clk):
  - uart_tx=1, tx_ready=1, tx_busy=0, frame_done=0.
  - State = IDLE; baud counter and bit counter cleared.
- Handshake:
  - Accept occurs on a clk edge where tx_valid && tx_ready.
  - tx_ready=1 only in IDLE.
  - tx_data is latched into a shift register at accept; later changes to tx_data are ignored.
  - tx_valid without tx_ready: no effect, no error.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept. On the same edge: uart_tx<=0, tx_busy<=1, tx_ready<=0, baud counter<=0.
  - Each bit period lasts exactly BAUD_DIV clk cycles; the baud counter counts 0..BAUD_DIV-1.
  - A bit boundary is the edge where the counter equals BAUD_DIV-1.
  - START -> DATA at boundary; uart_tx <= data bit 0.
  - DATA: shift at each boundary. After DATA_BITS bits:
    - -> PARITY if PARITY!=0, else -> STOP.
  - PARITY value:
    - odd: uart_tx = ~^data.
    - even: uart_tx = ^data.
    - Computed over the latched DATA_BITS bits only.
  - STOP: uart_tx=1 for STOP_BITS bit periods.
  - STOP -> IDLE at the final boundary. On that edge: frame_done<=1 (one cycle), tx_ready<=1, tx_busy<=0.
- Latency:
  - uart_tx falls on the first edge after accept.
  - Frame = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_DIV cycles.
- Back-to-back:
  - If tx_valid is held, the next accept occurs in the cycle tx_ready returns high.
  - Resulting gap = exactly one clk cycle of idle-high beyond the stop period.
  - No other idle insertion.
- Width rules:
  - Bit counter sized for max(DATA_BITS, STOP_BITS).
  - Baud counter is $clog2(BAUD_DIV) bits.
  - No wrap beyond BAUD_DIV-1.
- Reset mid-frame: line returns high immediately (async), frame abandoned, no frame_done.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined:
  - Adds input port tx_break (1 bit).
  - When tx_break=1 while in IDLE: tx_ready is forced 0 and uart_tx is driven 0 continuously.
  - On deassert: uart_tx returns high for a minimum of 2*BAUD_DIV cycles (mark-after-break) before tx_ready reasserts.
  - tx_break asserted mid-frame is deferred until the frame reaches IDLE.
- Undefined:
  - No tx_break port, no break logic.
  - Behaviour identical to the above with break never active.

Test Plan (CLK_FREQ=1_000_000, BAUD=100_000 -> BAUD_DIV=10 unless noted):
1. Reset, then idle 50 cycles -> uart_tx=1, tx_ready=1, tx_busy=0, frame_done never pulses.
2. 8N1, send 0xA5 -> line shows 0,1,0,1,0,0,1,0,1,1, each held 10 cycles; frame_done pulses at cycle 100 after accept; tx_ready high the same cycle.
3. DATA_BITS=7, PARITY=2, STOP_BITS=2, send 7'h41 -> start, 1000001, parity 0, stop 1,1; total 110 cycles.
4. Repeat with PARITY=1 -> parity bit 1.
5. tx_valid held high with 0x55 then 0xFF -> second start bit begins exactly 1 cycle after first frame_done; tx_data change mid-frame does not alter the first frame.
6. Assert rst at cycle 35 of a frame -> uart_tx=1 immediately, tx_ready=1 after release, no frame_done. With UART_TX_BREAK_EN: tx_break for 300 cycles -> line low 300 cycles, then high >=20 cycles before tx_ready=1.
